// File: rtl/sweep_regfile.sv
// sweep_regfile: 32x32 register file with two combinational read ports, one write port and a clear-sweep FSM
module sweep_regfile #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 ClearAll,
    output logic                 Ready
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {SWEEP, READY} state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic                 ready_q;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 wen;
    logic [ADDR_BITS-1:0] waddr;
    logic [WIDTH-1:0]     wdata;

    // Sweep/ready sequencing; the array itself is never reset, the sweep zeroes it instead
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == SWEEP) begin
            ptr_q <= ptr_q + 1'b1;
            if (&ptr_q) begin
                state_q <= READY;
                ready_q <= 1'b1;
            end
        end else if (ClearAll) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end
    end

    // Single write port shared by the sweep (zeroing) and normal writes (dropped while sweeping)
    always_comb begin
        wen   = (state_q == SWEEP) || (RegWrite && WriteRegister != '0);
        waddr = (state_q == SWEEP) ? ptr_q : WriteRegister;
        wdata = (state_q == SWEEP) ? '0 : WriteData;
    end

    // Plain storage with no reset so it maps onto RAM-style cells
    always_ff @(posedge Clk) begin
        if (wen) mem_q[waddr] <= wdata;
    end

    assign ReadData1 = (ready_q && ReadRegister1 != '0) ? mem_q[ReadRegister1] : '0;
    assign ReadData2 = (ready_q && ReadRegister2 != '0) ? mem_q[ReadRegister2] : '0;
    assign Ready     = ready_q;
endmodule

// File: tb/tb_sweep_regfile.sv
// tb_sweep_regfile: directed stimulus with a per-cycle reference model and literal spot checks
module tb_sweep_regfile;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  WriteRegister = '0;
    logic [31:0] WriteData = '0;
    logic        RegWrite = 1'b0;
    logic        ClearAll = 1'b0;
    logic        Ready;

    int n_cmp = 0;
    int n_err = 0;

    sweep_regfile dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite(RegWrite), .ClearAll(ClearAll), .Ready(Ready)
    );

    always #5 Clk = ~Clk;

    // Reference model: array contents plus "how many edges of the current clear have elapsed"
    logic [31:0] mdl [32];
    bit          busy = 1'b1;
    int          swept = 0;

    initial for (int i = 0; i < 32; i++) mdl[i] = '0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy  = 1'b1;
            swept = 0;
        end else if (busy) begin
            mdl[swept] = '0;
            swept++;
            if (swept == 32) busy = 1'b0;
        end else begin
            if (RegWrite && WriteRegister != 0) mdl[WriteRegister] = WriteData;
            if (ClearAll) begin
                busy  = 1'b1;
                swept = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare outputs against the model away from the active edge
    always @(negedge Clk) begin
        chk("ready", {31'b0, Ready}, {31'b0, !busy});
        chk("rd1", ReadData1, (busy || ReadRegister1 == 0) ? 32'h0 : mdl[ReadRegister1]);
        chk("rd2", ReadData2, (busy || ReadRegister2 == 0) ? 32'h0 : mdl[ReadRegister2]);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WriteRegister = a;
        WriteData     = d;
        RegWrite      = 1'b1;
        step();
        RegWrite      = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (Ready) return;
        end
        chk("ready_timeout", {31'b0, Ready}, 32'h1);
    endtask

    int n;

    initial begin
        Reset_n = 1'b0;
        #12;
        step();
        Reset_n = 1'b1;
        wait_ready(n);
        chk("t1_first_ready_edges", n, 32);
        for (int i = 0; i < 32; i++) begin
            rd(i[4:0], 5'(31 - i));
            chk("t1_rd1_zero", ReadData1, 32'h0);
            chk("t1_rd2_zero", ReadData2, 32'h0);
            step();
        end
        wr(2, 42);
        rd(2, 2);
        chk("t2_r2_p1", ReadData1, 32'd42);
        chk("t2_r2_p2", ReadData2, 32'd42);
        WriteRegister = 10;
        WriteData     = 15;
        step();
        rd(10, 10);
        chk("t2_r10_nowrite", ReadData1, 32'h0);
        wr(15, 15);
        rd(15, 20);
        chk("t3_r15", ReadData1, 32'd15);
        chk("t3_r20", ReadData2, 32'h0);
        wr(0, 15);
        rd(0, 0);
        chk("t3_r0", ReadData1, 32'h0);
        for (int i = 1; i < 32; i++) wr(i[4:0], i);
        rd(31, 9);
        chk("t4_r31_filled", ReadData1, 32'd31);
        chk("t4_r9_filled", ReadData2, 32'd9);
        ClearAll = 1'b1;
        step();
        ClearAll = 1'b0;
        chk("t4_ready_low", {31'b0, Ready}, 32'h0);
        chk("t4_rd_zero_in_sweep", ReadData1, 32'h0);
        wr(5, 55);
        wait_ready(n);
        chk("t4_sweep_edges", n + 1, 32);
        rd(5, 31);
        chk("t4_r5_lost", ReadData1, 32'h0);
        chk("t4_r31_cleared", ReadData2, 32'h0);
        wr(3, 33);
        ClearAll = 1'b1;
        step();
        ClearAll = 1'b0;
        repeat (10) step();
        Reset_n = 1'b0;
        #2;
        chk("t5_ready_in_reset", {31'b0, Ready}, 32'h0);
        step();
        Reset_n = 1'b1;
        wait_ready(n);
        chk("t5_restart_edges", n, 32);
        rd(3, 3);
        chk("t5_r3_cleared", ReadData1, 32'h0);
        WriteRegister = 7;
        WriteData     = 32'hDEADBEEF;
        RegWrite      = 1'b1;
        ClearAll      = 1'b1;
        step();
        RegWrite      = 1'b0;
        ClearAll      = 1'b0;
        chk("t6_ready_low", {31'b0, Ready}, 32'h0);
        repeat (5) step();
        ClearAll = 1'b1;
        step();
        ClearAll = 1'b0;
        wait_ready(n);
        chk("t6_on_schedule", n + 6, 32);
        rd(7, 7);
        chk("t6_r7_p1", ReadData1, 32'h0);
        chk("t6_r7_p2", ReadData2, 32'h0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
